// File: rtl/rf_wb_scheduler_if.sv
// rtl/rf_wb_scheduler_if.sv - writeback requester bundle (valid/ready with packed per-requester addr/data)
interface rf_wb_scheduler_if #(
    parameter int NREQ  = 2,
    parameter int ADDR  = 5,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       wb_valid;
    logic [NREQ*ADDR-1:0]  wb_addr;
    logic [NREQ*WIDTH-1:0] wb_data;
    logic [NREQ-1:0]       wb_ready;

    modport master (output wb_valid, output wb_addr, output wb_data, input wb_ready);
    modport slave  (input wb_valid, input wb_addr, input wb_data, output wb_ready);
endinterface

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - round-robin regfile write port scheduler with busy scoreboard
module rf_wb_scheduler #(
    parameter int LENGTH = 32,
    parameter int ADDR   = 5,
    parameter int WIDTH  = 32,
    parameter int NREQ   = 2
) (
    input  logic              clk,
    input  logic              reset,
    rf_wb_scheduler_if.slave  wb,
    output logic              write_enable,
    output logic [ADDR-1:0]   write_address,
    output logic [WIDTH-1:0]  write_data,
    input  logic              issue_valid,
    input  logic [ADDR-1:0]   issue_rs1,
    input  logic [ADDR-1:0]   issue_rs2,
    input  logic [ADDR-1:0]   issue_rd,
    output logic              issue_ready,
    output logic [LENGTH-1:0] busy
);
    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [RRW-1:0]    rr_q, rr_d;
    logic              gnt_found;
    logic [RRW-1:0]    gnt_idx;
    logic [ADDR-1:0]   gnt_addr;
    logic [WIDTH-1:0]  gnt_data;
    logic [NREQ-1:0]   ready_c;

    logic              we_q, we_d;
    logic [ADDR-1:0]   waddr_q, waddr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [LENGTH-1:0] busy_q, busy_d;
    logic              hazard;

    // Two passes give the wrap-around search: indices at/after rr first, then those below it.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_addr  = '0;
        gnt_data  = '0;
        ready_c   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!gnt_found && wb.wb_valid[j] && (j >= int'(rr_q))) begin
                gnt_found = 1'b1;
                gnt_idx   = j[RRW-1:0];
                gnt_addr  = wb.wb_addr[j*ADDR +: ADDR];
                gnt_data  = wb.wb_data[j*WIDTH +: WIDTH];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!gnt_found && wb.wb_valid[j] && (j < int'(rr_q))) begin
                gnt_found = 1'b1;
                gnt_idx   = j[RRW-1:0];
                gnt_addr  = wb.wb_addr[j*ADDR +: ADDR];
                gnt_data  = wb.wb_data[j*WIDTH +: WIDTH];
            end
        end
        if (gnt_found) begin
            ready_c[gnt_idx] = 1'b1;
        end
    end

    assign wb.wb_ready = ready_c;

    always_comb begin
        rr_d    = rr_q;
        we_d    = gnt_found && (gnt_addr != '0);
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (gnt_found) begin
            rr_d    = (gnt_idx == RRW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            waddr_d = gnt_addr;
            wdata_d = gnt_data;
        end
    end

    // No bypass: a register stays busy until its registered write has committed.
    assign hazard = ((issue_rs1 != '0) && busy_q[issue_rs1])
                 || ((issue_rs2 != '0) && busy_q[issue_rs2])
                 || ((issue_rd  != '0) && busy_q[issue_rd]);
    assign issue_ready = !hazard;

    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign write_enable  = we_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign busy          = busy_q;
endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

- Sequences all traffic into the single write port of the 32x32 integer register file.
- Round-robin arbitration of NREQ writeback requesters (ALU, load unit, ...) onto that port, with valid/ready handshakes and a registered write command.
- Keeps a per-register busy scoreboard, and stalls the issue stage on RAW/WAW hazards until the pending write has committed.
- Sits between the execute/writeback stage and the register file; drives its write_enable/write_address/write_data inputs directly.

## Interface
- LENGTH, 32, number of architectural registers (busy vector width)
- ADDR, 5, register address width
- WIDTH, 32, data width
- NREQ, 2, number of writeback requesters (2..8)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- wb_valid  input  NREQ  requester i has a write pending
- wb_addr  input  NREQ*ADDR  requester i destination at [i*ADDR +: ADDR]
- wb_data  input  NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
- wb_ready  output  NREQ  one-hot grant; transfer on wb_valid[i] & wb_ready[i]
- write_enable  output  1  registered regfile write strobe
- write_address  output  ADDR  registered regfile write address
- write_data  output  WIDTH  registered regfile write data
- issue_valid  input  1  issue stage presents an instruction
- issue_rs1, issue_rs2, issue_rd  input  ADDR each  source/destination registers
- issue_ready  output  1  no hazard; instruction accepted on issue_valid & issue_ready
- busy  output  LENGTH  scoreboard; busy[0] is constant 0

## Operation
- **Arbiter**
  - Round-robin pointer rr (0..NREQ-1). The grant goes to the lowest index j, searched from rr upward with wrap, where wb_valid[j]=1.
  - wb_ready is combinational: one-hot on the grant, all zero when no wb_valid.
  - On a transfer by j, rr <= (j+1) mod NREQ. Otherwise rr holds.
  - Requesters must hold valid/addr/data stable until the transfer.
- **Write command register**
  - Updated every cycle.
  - write_enable <= transfer & (granted addr != 0).
  - write_address/write_data <= granted addr/data on a transfer; otherwise hold.
  - A transfer to x0 is accepted (handshake completes, rr advances) but produces no write.
- **Scoreboard**
  - Set: at an issue acceptance with issue_rd != 0, busy[issue_rd] <= 1.
  - Clear: when write_enable is high (registered command), busy[write_address] <= 0 at the same edge the register file commits the data.
  - Set and clear at the same edge target different registers: a busy rd always stalls, so set/clear of the same index cannot coincide. Both apply.
  - A writeback to a non-busy register still writes; its clear is a no-op.
- **Hazard check**
  - issue_ready is combinational from the current busy state only (no bypass):
  - issue_ready = !((rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]) | (rd!=0 & busy[rd])).
  - issue_ready is evaluated independently of issue_valid.

## Timing
- **Reset** (reset=0, asynchronous): busy=0, write_enable=0, write_address=0, write_data=0, rr=0.
  - wb_ready then follows the combinational grant (rr=0). issue_ready=1.
  - Reset mid-operation discards any registered, uncommitted write and all busy bits.
- **Writeback latency:** transfer in cycle t → write_enable=1 during t+1 → regfile updated and busy bit cleared at the end of t+1.
- **Dependent issue:** first possible issue_ready=1 for that register is cycle t+2. The regfile read in t+2 returns the new value.
- **Throughput:** one writeback per cycle. Back-to-back transfers produce a continuous write_enable stream.
- **Issue-to-clear:** issue accepted in cycle s → busy set from s+1. Earliest clear is at the end of s+1, if a transfer for that rd happened in s.

## Test plan
- **Reset values:** hold reset=0 for 2 cycles, then release → busy=0, write_enable=0, write_address=0, write_data=0, issue_ready=1. With wb_valid=2'b11, wb_ready=2'b01 (rr=0).
- **Round-robin fairness:** both requesters valid continuously with rd 3 and 4 → grants alternate 0,1,0,1. write_address sequence is 3,4,3,4, each one cycle after its grant.
- **Hazard stall:**
  - Issue rd=5 → busy[5]=1 next cycle.
  - Issue rs1=5 → issue_ready=0.
  - Requester 1 writes 5 with data 0xDEADBEEF in cycle t → write_enable in t+1, busy[5]=0 and issue_ready=1 in t+2. The regfile reads 0xDEADBEEF at x5.
- **x0 handling:**
  - Issue rd=0 → busy unchanged.
  - wb_addr=0 with valid → wb_ready=1, write_enable stays 0, rr advances.
  - rs1=0 never stalls.
- **WAW and simultaneous events:**
  - busy[7]=1 and issue rd=7 → stall.
  - In the same cycle a write of 7 commits while issue rd=9 is accepted → after the edge busy[7]=0 and busy[9]=1.
- **Reset mid-operation:** transfer to rd=6 in cycle t, then reset=0 asserted asynchronously during t+1 → write_enable drops to 0 immediately, busy=0. Register 6 keeps its old value.
